// File: rtl/nn_stream_decoder.sv
// Sign-magnitude stochastic stream to signed binary count over a fixed window
// of valid samples, with the result held behind a valid/ready output register.
module nn_stream_decoder #(
  parameter int WINDOW     = 256,
  parameter int CNT_W      = 9,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic             CLK,
  input  logic             INIT,
  input  logic             START,
  input  logic             EN,
  input  logic             IN,
  input  logic             SIGN_IN,
  input  logic             OUT_READY,
  output logic [CNT_W:0]   VALUE,
  output logic             OUT_VALID,
  output logic             BUSY,
  output logic             OVERRUN
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  state_t                 state_q, state_d;
  logic signed [CNT_W:0]  acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W:0]         value_q, value_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;

  logic signed [CNT_W:0]  step;
  logic signed [CNT_W:0]  acc_sum;
  logic                   transfer;

  always_comb begin
    step = '0;
    if (IN) begin
      step = SIGN_IN ? {(CNT_W+1){1'b1}} : (CNT_W+1)'(1);
    end
    acc_sum  = acc_q + step;
    transfer = valid_q & OUT_READY;
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (transfer) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_ACCUM;
          acc_d     = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (START) begin
          // Restart discards this cycle's sample but leaves the held result alone.
          acc_d     = '0;
          cnt_d     = '0;
          overrun_d = 1'b0;
        end else if (EN) begin
          if (cnt_q == LAST_CNT) begin
            acc_d = '0;
            cnt_d = '0;
            // A slot is free if empty or being drained on this same edge.
            if (!valid_q || transfer) begin
              value_d = acc_sum;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            if (!CONTINUOUS) begin
              state_d = ST_DONE;
            end
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (transfer) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign VALUE     = value_q;
  assign OUT_VALID = valid_q;
  assign BUSY      = (state_q == ST_ACCUM);
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_nn_stream_decoder.sv
// Bench for nn_stream_decoder: one single-shot and one continuous instance
// share stimulus; expected results are queued as windows are driven.
module tb_nn_stream_decoder;

  localparam int WINDOW = 16;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  logic init = 1'b0, start = 1'b0, en = 1'b0, in_bit = 1'b0, sign_in = 1'b0, out_ready = 1'b0;
  logic signed [CNT_W:0] v0, v1;
  logic ov0, b0, or0, ov1, b1, or1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int e;

  always #5 clk = ~clk;

  nn_stream_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W), .CONTINUOUS(1'b0)) u_single (
    .CLK(clk), .INIT(init), .START(start), .EN(en), .IN(in_bit), .SIGN_IN(sign_in),
    .OUT_READY(out_ready), .VALUE(v0), .OUT_VALID(ov0), .BUSY(b0), .OVERRUN(or0)
  );

  nn_stream_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W), .CONTINUOUS(1'b1)) u_cont (
    .CLK(clk), .INIT(init), .START(start), .EN(en), .IN(in_bit), .SIGN_IN(sign_in),
    .OUT_READY(out_ready), .VALUE(v1), .OUT_VALID(ov1), .BUSY(b1), .OVERRUN(or1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic s_en, input logic s_in, input logic s_sign);
    en = s_en; in_bit = s_in; sign_in = s_sign;
    tick();
    en = 1'b0; in_bit = 1'b0; sign_in = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic test_reset();
    do_init();
    n_cmp++; if (v0 !== 6'sd0 || ov0 !== 1'b0 || b0 !== 1'b0 || or0 !== 1'b0) begin n_bad++; $display("FAIL reset_single got v=%0d valid=%0b busy=%0b ovr=%0b want 0 0 0 0", v0, ov0, b0, or0); end
    n_cmp++; if (v1 !== 6'sd0 || ov1 !== 1'b0 || b1 !== 1'b0 || or1 !== 1'b0) begin n_bad++; $display("FAIL reset_cont got v=%0d valid=%0b busy=%0b ovr=%0b want 0 0 0 0", v1, ov1, b1, or1); end
    $display("test_reset done");
  endtask

  task automatic test_single_window();
    int early = 0;
    do_init();
    pulse_start();
    n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL t1_busy got %0b want 1", b0); end
    exp_q.push_back(16);
    for (int i = 0; i < WINDOW - 1; i++) begin
      samp(1'b1, 1'b1, 1'b0);
      if (ov0 !== 1'b0) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL t1_early_valid got %0d early cycles want 0", early); end
    samp(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (ov0 !== 1'b1 || v0 !== 6'(e)) begin n_bad++; $display("FAIL t1_result got valid=%0b v=%0d want 1 %0d", ov0, v0, e); end
    n_cmp++; if (b0 !== 1'b0) begin n_bad++; $display("FAIL t1_done_busy got %0b want 0", b0); end
    samp(1'b1, 1'b1, 1'b1);
    pulse_start();
    n_cmp++; if (ov0 !== 1'b1 || v0 !== 6'(e) || b0 !== 1'b0) begin n_bad++; $display("FAIL t1_hold got valid=%0b v=%0d busy=%0b want 1 %0d 0", ov0, v0, b0, e); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (ov0 !== 1'b0 || v0 !== 6'(e)) begin n_bad++; $display("FAIL t1_transfer got valid=%0b v=%0d want 0 %0d", ov0, v0, e); end
    samp(1'b1, 1'b1, 1'b0);
    n_cmp++; if (b0 !== 1'b0) begin n_bad++; $display("FAIL t1_idle got busy=%0b want 0", b0); end
    $display("test_single_window: result %0d", e);
  endtask

  task automatic test_gaps();
    int model = 0;
    int nvalid = 0;
    int cyc = 0;
    logic s_in, s_sign;
    do_init();
    pulse_start();
    while (nvalid < WINDOW) begin
      if (cyc % 3 == 2) begin
        samp(1'b0, 1'b1, 1'b0);
      end else begin
        s_in   = (nvalid < 14);
        s_sign = (nvalid >= 10);
        if (s_in) model += s_sign ? -1 : 1;
        if (nvalid == WINDOW - 1) begin
          n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL t2_latency got valid=%0b before last sample want 0", ov0); end
          exp_q.push_back(model);
        end
        samp(1'b1, s_in, s_sign);
        nvalid++;
      end
      cyc++;
    end
    e = exp_q.pop_front();
    n_cmp++; if (ov0 !== 1'b1 || v0 !== 6'(e)) begin n_bad++; $display("FAIL t2_result got valid=%0b v=%0d want 1 %0d", ov0, v0, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    $display("test_gaps: result %0d", e);
  endtask

  task automatic test_overrun();
    do_init();
    pulse_start();
    exp_q.push_back(-16);
    for (int i = 0; i < WINDOW; i++) samp(1'b1, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_cmp++; if (ov1 !== 1'b1 || v1 !== 6'(e) || b1 !== 1'b1 || or1 !== 1'b0) begin n_bad++; $display("FAIL t3_first got valid=%0b v=%0d busy=%0b ovr=%0b want 1 %0d 1 0", ov1, v1, b1, or1, e); end
    for (int i = 0; i < WINDOW; i++) samp(1'b1, 1'b1, 1'b0);
    n_cmp++; if (ov1 !== 1'b1 || v1 !== 6'(e) || or1 !== 1'b1) begin n_bad++; $display("FAIL t3_overrun got valid=%0b v=%0d ovr=%0b want 1 %0d 1", ov1, v1, or1, e); end
    pulse_start();
    n_cmp++; if (or1 !== 1'b0 || b1 !== 1'b1 || ov1 !== 1'b1) begin n_bad++; $display("FAIL t3_start_clear got ovr=%0b busy=%0b valid=%0b want 0 1 1", or1, b1, ov1); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (ov1 !== 1'b0) begin n_bad++; $display("FAIL t3_drain got valid=%0b want 0", ov1); end
    $display("test_overrun: held %0d", e);
  endtask

  task automatic test_back_to_back();
    do_init();
    pulse_start();
    exp_q.push_back(5);
    for (int i = 0; i < WINDOW; i++) samp(1'b1, (i < 5), 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (ov1 !== 1'b1 || v1 !== 6'(e)) begin n_bad++; $display("FAIL t4_first got valid=%0b v=%0d want 1 %0d", ov1, v1, e); end
    exp_q.push_back(-3);
    for (int i = 0; i < WINDOW; i++) begin
      if (i == WINDOW - 1) out_ready = 1'b1;
      samp(1'b1, (i >= 10 && i < 13), 1'b1);
    end
    out_ready = 1'b0;
    e = exp_q.pop_front();
    n_cmp++; if (ov1 !== 1'b1 || v1 !== 6'(e) || or1 !== 1'b0) begin n_bad++; $display("FAIL t4_second got valid=%0b v=%0d ovr=%0b want 1 %0d 0", ov1, v1, or1, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    $display("test_back_to_back: result %0d", e);
  endtask

  task automatic test_restart();
    int early = 0;
    do_init();
    pulse_start();
    for (int i = 0; i < 9; i++) samp(1'b1, 1'b1, 1'b0);
    en = 1'b1; in_bit = 1'b1;
    pulse_start();
    en = 1'b0; in_bit = 1'b0;
    exp_q.push_back(0);
    for (int i = 0; i < WINDOW - 1; i++) begin
      samp(1'b1, 1'b0, 1'b1);
      if (ov0 !== 1'b0) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL t5_early_valid got %0d early cycles want 0", early); end
    samp(1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (ov0 !== 1'b1 || v0 !== 6'(e)) begin n_bad++; $display("FAIL t5_result got valid=%0b v=%0d want 1 %0d", ov0, v0, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    $display("test_restart: result %0d", e);
  endtask

  task automatic test_init_override();
    int busy_seen = 0;
    do_init();
    pulse_start();
    for (int i = 0; i < 7; i++) samp(1'b1, 1'b1, 1'b0);
    init = 1'b1; start = 1'b1; en = 1'b1; in_bit = 1'b1;
    tick();
    init = 1'b0; start = 1'b0; en = 1'b0; in_bit = 1'b0;
    n_cmp++; if (v0 !== 6'sd0 || ov0 !== 1'b0 || b0 !== 1'b0 || or0 !== 1'b0) begin n_bad++; $display("FAIL t6_mid_init got v=%0d valid=%0b busy=%0b ovr=%0b want 0 0 0 0", v0, ov0, b0, or0); end
    for (int i = 0; i < 20; i++) begin
      samp(1'b1, 1'b1, 1'b0);
      if (b0 !== 1'b0 || ov0 !== 1'b0) busy_seen++;
    end
    n_cmp++; if (busy_seen != 0) begin n_bad++; $display("FAIL t6_en_no_start got %0d active cycles want 0", busy_seen); end
    pulse_start();
    exp_q.push_back(16);
    for (int i = 0; i < WINDOW; i++) samp(1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (ov0 !== 1'b1 || v0 !== 6'(e)) begin n_bad++; $display("FAIL t6_done got valid=%0b v=%0d want 1 %0d", ov0, v0, e); end
    do_init();
    n_cmp++; if (v0 !== 6'sd0 || ov0 !== 1'b0 || b0 !== 1'b0 || or0 !== 1'b0) begin n_bad++; $display("FAIL t6_done_init got v=%0d valid=%0b busy=%0b ovr=%0b want 0 0 0 0", v0, ov0, b0, or0); end
    $display("test_init_override done");
  endtask

  initial begin
    tick();
    test_reset();
    test_single_window();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_restart();
    test_init_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
